// File: rtl/light_countdown_pkg.sv
// Shared light-code constants and the BCD helper used to build the per-phase load values.
package light_countdown_pkg;

    localparam int RED = 2;
    localparam int YEL = 1;
    localparam int GRN = 0;

    localparam logic [2:0] C_RED = 3'b100;
    localparam logic [2:0] C_YEL = 3'b010;
    localparam logic [2:0] C_GRN = 3'b001;
    localparam logic [2:0] C_OFF = 3'b000;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/light_countdown_if.sv
// Street light inputs and countdown display outputs for the two streets.
interface light_countdown_if;
    logic [2:0] street_a;
    logic [2:0] street_b;
    logic [3:0] a_tens;
    logic [3:0] a_ones;
    logic [3:0] b_tens;
    logic [3:0] b_ones;
    logic       blank_a;
    logic       blank_b;
    logic       fault;

    modport master (
        output street_a, street_b,
        input  a_tens, a_ones, b_tens, b_ones, blank_a, blank_b, fault
    );

    modport slave (
        input  street_a, street_b,
        output a_tens, a_ones, b_tens, b_ones, blank_a, blank_b, fault
    );
endinterface

// File: rtl/light_countdown_channel.sv
// One street's countdown: phase-change detect, seconds prescaler, saturating BCD down-counter, blank.
module countdown_channel
    import light_countdown_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int G_TIME   = 25,
    parameter int Y_TIME   = 3,
    parameter int R_TIME   = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       blank
);

    localparam int         PW    = $clog2(TICK_DIV);
    localparam logic [7:0] G_BCD = to_bcd(G_TIME);
    localparam logic [7:0] Y_BCD = to_bcd(Y_TIME);
    localparam logic [7:0] R_BCD = to_bcd(R_TIME);

    logic [2:0]    prev;
    logic [PW-1:0] presc;
    logic          valid;

    assign valid = $onehot(code);

    // 00 saturates; the count only leaves 00 through a reload.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] != 4'd0)      return {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return 8'h00;
    endfunction

    function automatic logic [7:0] load_value(input logic [2:0] c);
        case (c)
            C_RED:   return R_BCD;
            C_YEL:   return Y_BCD;
            default: return G_BCD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= C_OFF;
            presc <= '0;
            tens  <= 4'd0;
            ones  <= 4'd0;
            blank <= 1'b1;
        end else if (valid) begin
            blank <= 1'b0;
            if (code != prev) begin
                {tens, ones} <= load_value(code);
                presc        <= '0;
                prev         <= code;
            end else if (presc == PW'(TICK_DIV - 1)) begin
                presc        <= '0;
                {tens, ones} <= bcd_dec({tens, ones});
            end else begin
                presc <= presc + 1'b1;
            end
        end else begin
            // Off or multi-hot: freeze the count; only an off code forgets the phase.
            blank <= 1'b1;
            if (code == C_OFF) prev <= C_OFF;
        end
    end

endmodule

// File: rtl/light_countdown.sv
// Countdown display driver for both streets plus sticky detection of conflicting or malformed codes.
module light_countdown
    import light_countdown_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int G_TIME   = 25,
    parameter int Y_TIME   = 3,
    parameter int R_TIME   = 28
) (
    input  logic              clk,
    input  logic              rst,
    light_countdown_if.slave  bus
);

    if (G_TIME < 1 || G_TIME > 99 || Y_TIME < 1 || Y_TIME > 99 || R_TIME < 1 || R_TIME > 99)
        $error("light_countdown: phase durations must be within 1..99");
    if (R_TIME != G_TIME + Y_TIME)
        $error("light_countdown: R_TIME must equal G_TIME + Y_TIME");
    if (TICK_DIV < 2)
        $error("light_countdown: TICK_DIV must be at least 2");

    logic valid_a, valid_b, multi_a, multi_b, conflict;

    assign valid_a  = $onehot(bus.street_a);
    assign valid_b  = $onehot(bus.street_b);
    assign multi_a  = !$onehot0(bus.street_a);
    assign multi_b  = !$onehot0(bus.street_b);
    assign conflict = valid_a && valid_b && !bus.street_a[RED] && !bus.street_b[RED];

    always_ff @(posedge clk) begin
        if (rst) bus.fault <= 1'b0;
        else if (conflict || multi_a || multi_b) bus.fault <= 1'b1;
    end

    countdown_channel #(
        .TICK_DIV(TICK_DIV), .G_TIME(G_TIME), .Y_TIME(Y_TIME), .R_TIME(R_TIME)
    ) u_chan_a (
        .clk  (clk),
        .rst  (rst),
        .code (bus.street_a),
        .tens (bus.a_tens),
        .ones (bus.a_ones),
        .blank(bus.blank_a)
    );

    countdown_channel #(
        .TICK_DIV(TICK_DIV), .G_TIME(G_TIME), .Y_TIME(Y_TIME), .R_TIME(R_TIME)
    ) u_chan_b (
        .clk  (clk),
        .rst  (rst),
        .code (bus.street_b),
        .tens (bus.b_tens),
        .ones (bus.b_ones),
        .blank(bus.blank_b)
    );

endmodule

// File: tb/tb_light_countdown.sv
// Directed bench for light_countdown: main instance G/Y/R = 5/2/7, second instance 10/2/12 for BCD borrow.
module tb_light_countdown;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    light_countdown_if bus ();
    light_countdown_if bus2 ();

    light_countdown #(.TICK_DIV(4), .G_TIME(5), .Y_TIME(2), .R_TIME(7)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    light_countdown #(.TICK_DIV(4), .G_TIME(10), .Y_TIME(2), .R_TIME(12)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.street_a = 3'b000;  bus.street_b = 3'b000;
        bus2.street_a = 3'b000; bus2.street_b = 3'b000;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0000)
            $display("FAIL reset_digits: got %h want 0000", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
        total++;
        if ({bus.blank_a, bus.blank_b} !== 2'b11)
            $display("FAIL reset_blank: got %b want 11", {bus.blank_a, bus.blank_b});
        else passed++;
        total++;
        if (bus.fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", bus.fault);
        else passed++;
    endtask

    task automatic test_green_countdown();
        do_reset();
        bus.street_a = 3'b001; bus.street_b = 3'b100;
        step(1);
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0507)
            $display("FAIL green_load: got %h want 0507", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
        total++;
        if ({bus.blank_a, bus.blank_b} !== 2'b00)
            $display("FAIL green_blank: got %b want 00", {bus.blank_a, bus.blank_b});
        else passed++;
        step(3);
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0507)
            $display("FAIL green_no_early_tick: got %h want 0507", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
        step(1);
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0406)
            $display("FAIL green_tick1: got %h want 0406", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
        step(20);
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0001)
            $display("FAIL green_after24: got %h want 0001", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
        step(4);
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0000)
            $display("FAIL green_saturate: got %h want 0000", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
        total++;
        if (bus.fault !== 1'b0) $display("FAIL green_fault: got %b want 0", bus.fault);
        else passed++;
    endtask

    task automatic test_yellow_reload_on_tick();
        do_reset();
        bus.street_a = 3'b001; bus.street_b = 3'b100;
        step(1);
        step(3);
        bus.street_a = 3'b010;
        step(1);
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0206)
            $display("FAIL yellow_load_wins: got %h want 0206", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
        step(3);
        total++;
        if ({bus.a_tens, bus.a_ones} !== 8'h02)
            $display("FAIL yellow_hold: got %h want 02", {bus.a_tens, bus.a_ones});
        else passed++;
        step(1);
        total++;
        if ({bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones} !== 16'h0105)
            $display("FAIL yellow_tick: got %h want 0105", {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones});
        else passed++;
    endtask

    task automatic test_bcd_borrow();
        logic [7:0] want [4];
        want[0] = 8'h12; want[1] = 8'h11; want[2] = 8'h10; want[3] = 8'h09;
        do_reset();
        bus2.street_a = 3'b010; bus2.street_b = 3'b100;
        step(1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(4);
            total++;
            if ({bus2.b_tens, bus2.b_ones} !== want[i])
                $display("FAIL borrow_step%0d: got %h want %h", i, {bus2.b_tens, bus2.b_ones}, want[i]);
            else passed++;
        end
        step(4);
        total++;
        if ({bus2.b_tens, bus2.b_ones} !== 8'h08)
            $display("FAIL borrow_after: got %h want 08", {bus2.b_tens, bus2.b_ones});
        else passed++;
        bus2.street_a = 3'b000; bus2.street_b = 3'b000;
    endtask

    task automatic test_conflict_fault();
        do_reset();
        bus.street_a = 3'b001; bus.street_b = 3'b100;
        step(1);
        total++;
        if (bus.fault !== 1'b0) $display("FAIL conflict_pre: got %b want 0", bus.fault);
        else passed++;
        bus.street_b = 3'b001;
        step(1);
        total++;
        if (bus.fault !== 1'b1) $display("FAIL conflict_set: got %b want 1", bus.fault);
        else passed++;
        bus.street_b = 3'b100;
        step(3);
        total++;
        if (bus.fault !== 1'b1) $display("FAIL conflict_sticky: got %b want 1", bus.fault);
        else passed++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++;
        if (bus.fault !== 1'b0) $display("FAIL conflict_clear: got %b want 0", bus.fault);
        else passed++;
        total++;
        if ({bus.a_tens, bus.a_ones, bus.blank_a} !== 9'h001)
            $display("FAIL reset_midcount: got %h want 001", {bus.a_tens, bus.a_ones, bus.blank_a});
        else passed++;
    endtask

    task automatic test_malformed_recovery();
        do_reset();
        bus.street_a = 3'b001; bus.street_b = 3'b100;
        step(5);
        total++;
        if ({bus.a_tens, bus.a_ones} !== 8'h04)
            $display("FAIL malformed_pre: got %h want 04", {bus.a_tens, bus.a_ones});
        else passed++;
        bus.street_a = 3'b011;
        step(1);
        total++;
        if ({bus.blank_a, bus.fault} !== 2'b11)
            $display("FAIL malformed_flags: got %b want 11", {bus.blank_a, bus.fault});
        else passed++;
        step(4);
        total++;
        if ({bus.a_tens, bus.a_ones} !== 8'h04)
            $display("FAIL malformed_frozen: got %h want 04", {bus.a_tens, bus.a_ones});
        else passed++;
        bus.street_a = 3'b000;
        step(1);
        total++;
        if ({bus.blank_a, bus.a_tens, bus.a_ones} !== 9'h104)
            $display("FAIL off_blank: got %h want 104", {bus.blank_a, bus.a_tens, bus.a_ones});
        else passed++;
        bus.street_a = 3'b001;
        step(1);
        total++;
        if ({bus.blank_a, bus.a_tens, bus.a_ones} !== 9'h005)
            $display("FAIL recover_load: got %h want 005", {bus.blank_a, bus.a_tens, bus.a_ones});
        else passed++;
        total++;
        if (bus.fault !== 1'b1) $display("FAIL recover_fault_sticky: got %b want 1", bus.fault);
        else passed++;
    endtask

    initial begin
        bus.street_a = 3'b000;  bus.street_b = 3'b000;
        bus2.street_a = 3'b000; bus2.street_b = 3'b000;
        test_reset();
        test_green_countdown();
        test_yellow_reload_on_tick();
        test_bcd_borrow();
        test_conflict_fault();
        test_malformed_recovery();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
